ctrl_mc: RTL and testbench

- Parametrised multi-cycle control FSM for the SISC datapath.
- Adds the following on top of the current control unit:
  - load/store sequencing (LOD, STR) with a memory ready/request handshake on instruction fetch and data access;
  - a memory wait timeout that enters a fault state;
  - an optional short branch path;
  - a clean halt state instead of a simulator stop.
- Sits between IR/statreg and the datapath muxes, PC, RF, ALU and memory.

---
 rtl/ctrl_mc_pkg.sv | 35 +++
 rtl/ctrl_mc_if.sv | 37 +++
 rtl/ctrl_wait_timer.sv | 29 ++
 rtl/ctrl_mc.sv | 116 +++++++++++
 tb/tb_ctrl_mc.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_mc_pkg.sv
// Shared constants for the SISC multi-cycle control unit: opcodes, FSM states, ALU op codes.
package ctrl_mc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  localparam logic [1:0] ALU_REG      = 2'b00;
  localparam logic [1:0] ALU_IMM      = 2'b01;
  localparam logic [1:0] ALU_NOST     = 2'b10;
  localparam logic [1:0] ALU_NOST_IMM = 2'b11;

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_NOOP, OP_LOD, OP_STR, OP_BRA, OP_BRR,
                      OP_BNE, OP_BNR, OP_ALU, OP_HLT};
  endfunction

endpackage

// File: rtl/ctrl_mc_if.sv
// Control bundle between the control FSM (master) and the IR/statreg/datapath/memory side (slave).
interface ctrl_mc_if #(
  parameter int OP_W = 4,
  parameter int MM_W = 4
);
  logic [OP_W-1:0] opcode;
  logic [MM_W-1:0] mm;
  logic [MM_W-1:0] stat;
  logic            mem_rdy;
  logic            rf_we;
  logic [1:0]      alu_op;
  logic            wb_sel;
  logic            br_sel;
  logic            rb_sel;
  logic            ir_load;
  logic            pc_sel;
  logic            pc_write;
  logic            pc_rst;
  logic            mm_sel;
  logic            mem_req;
  logic            dm_we;
  logic            halted;
  logic            fault;
  logic            illegal;

  modport master (
    input  opcode, mm, stat, mem_rdy,
    output rf_we, alu_op, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write,
           pc_rst, mm_sel, mem_req, dm_we, halted, fault, illegal
  );

  modport slave (
    output opcode, mm, stat, mem_rdy,
    input  rf_we, alu_op, wb_sel, br_sel, rb_sel, ir_load, pc_sel, pc_write,
           pc_rst, mm_sel, mem_req, dm_we, halted, fault, illegal
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive cycles of an unanswered memory request; expired flags the timeout limit.
module ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic active,
  input  logic clear,
  output logic expired
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
      logic [CNT_W-1:0] r_cnt;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
        if (rst_f || clear || !active) r_cnt <= '0;
        else                           r_cnt <= r_cnt + CNT_W'(1);
      end

      assign expired = (r_cnt == CNT_W'(MEM_TIMEOUT));
    end else begin : g_none
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM for the SISC datapath with memory handshake, wait timeout, halt and fault.
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MM_W        = 4,
  parameter int IMM_MODE    = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int BR_SHORT    = 1
) (
  input logic       clk,
  input logic       rst_f,
  ctrl_mc_if.master bus
);

  state_e     r_state;
  logic [3:0] w_op;
  logic       w_cond, w_imm, w_is_mem, w_is_str, w_is_br, w_taken, w_expired;

  assign w_op     = 4'(bus.opcode);
  assign w_cond   = |(bus.mm & bus.stat);
  assign w_imm    = (bus.mm == MM_W'(IMM_MODE));
  assign w_is_mem = (w_op == OP_LOD) || (w_op == OP_STR);
  assign w_is_str = (w_op == OP_STR);
  assign w_is_br  = w_op inside {OP_BRA, OP_BRR, OP_BNE, OP_BNR};
  // BNE/BNR are "branch if none of the masked flags set", so mm = 0 always branches.
  assign w_taken  = ((w_op == OP_BRA) || (w_op == OP_BRR)) ? w_cond :
                    ((w_op == OP_BNE) || (w_op == OP_BNR)) ? !w_cond : 1'b0;

  ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_f   (rst_f),
    .active  (bus.mem_req & ~bus.mem_rdy),
    .clear   (bus.mem_rdy | w_expired),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst_f) begin
      r_state <= S_RESET;
    end else begin
      case (r_state)
        S_RESET:     r_state <= S_FETCH;
        S_FETCH:     if (bus.mem_rdy)    r_state <= S_DECODE;
                     else if (w_expired) r_state <= S_FAULT;
        S_DECODE:    if (w_op == OP_HLT)               r_state <= S_HALT;
                     else if (BR_SHORT != 0 && w_is_br) r_state <= S_FETCH;
                     else                               r_state <= S_EXECUTE;
        S_EXECUTE:   r_state <= S_MEM;
        S_MEM:       if (!w_is_mem || bus.mem_rdy) r_state <= S_WRITEBACK;
                     else if (w_expired)           r_state <= S_FAULT;
        S_WRITEBACK: r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        S_FAULT:     r_state <= S_FAULT;
        default:     r_state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.rf_we    = 1'b0;
    bus.alu_op   = ALU_NOST;
    bus.wb_sel   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.rb_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.mm_sel   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.dm_we    = 1'b0;
    bus.halted   = 1'b0;
    bus.fault    = 1'b0;
    bus.illegal  = 1'b0;
    case (r_state)
      S_RESET: bus.pc_rst = 1'b1;
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_load  = bus.mem_rdy;
        bus.pc_write = bus.mem_rdy;
      end
      S_DECODE: begin
        bus.illegal  = !is_legal(w_op);
        bus.br_sel   = (w_op == OP_BRA) || (w_op == OP_BNE);
        bus.pc_sel   = w_taken;
        bus.pc_write = w_taken;
      end
      S_EXECUTE: begin
        if (w_op == OP_ALU) bus.alu_op = w_imm ? ALU_IMM : ALU_REG;
        else if (w_is_mem)  bus.alu_op = ALU_NOST_IMM;
        bus.rb_sel = w_is_str;
      end
      S_MEM: begin
        if (w_op == OP_ALU) begin
          bus.alu_op = w_imm ? ALU_NOST_IMM : ALU_NOST;
        end else if (w_is_mem) begin
          bus.alu_op  = ALU_NOST_IMM;
          bus.mm_sel  = 1'b1;
          bus.mem_req = 1'b1;
          bus.dm_we   = w_is_str;
          bus.rb_sel  = w_is_str;
        end
      end
      S_WRITEBACK: begin
        bus.rf_we  = (w_op == OP_ALU) || (w_op == OP_LOD);
        bus.wb_sel = (w_op == OP_LOD);
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: each cycle the full output vector is compared with a hand-built value.
module tb_ctrl_mc;

  logic clk = 1'b0;
  logic rst_f;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ctrl_mc_if #(.OP_W(4), .MM_W(4)) bus ();

  ctrl_mc #(
    .OP_W(4), .MM_W(4), .IMM_MODE(8), .MEM_TIMEOUT(4), .BR_SHORT(1)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.master)
  );

  // Output vector: {rf_we, alu_op[1:0], wb_sel, br_sel, rb_sel, ir_load, pc_sel,
  //                 pc_write, pc_rst, mm_sel, mem_req, dm_we, halted, fault, illegal}
  localparam logic [15:0] B_RFWE  = 16'h8000;
  localparam logic [15:0] A_REG   = 16'h0000;
  localparam logic [15:0] A_IMM   = 16'h2000;
  localparam logic [15:0] A_NOST  = 16'h4000;
  localparam logic [15:0] A_NI    = 16'h6000;
  localparam logic [15:0] B_WBSEL = 16'h1000;
  localparam logic [15:0] B_BRSEL = 16'h0800;
  localparam logic [15:0] B_RBSEL = 16'h0400;
  localparam logic [15:0] B_IRLD  = 16'h0200;
  localparam logic [15:0] B_PCSEL = 16'h0100;
  localparam logic [15:0] B_PCWR  = 16'h0080;
  localparam logic [15:0] B_PCRST = 16'h0040;
  localparam logic [15:0] B_MMSEL = 16'h0020;
  localparam logic [15:0] B_MREQ  = 16'h0010;
  localparam logic [15:0] B_DMWE  = 16'h0008;
  localparam logic [15:0] B_HALT  = 16'h0004;
  localparam logic [15:0] B_FAULT = 16'h0002;
  localparam logic [15:0] B_ILL   = 16'h0001;

  localparam logic [15:0] V_RESET   = A_NOST | B_PCRST;
  localparam logic [15:0] V_F_WAIT  = A_NOST | B_MREQ;
  localparam logic [15:0] V_F_RDY   = A_NOST | B_MREQ | B_IRLD | B_PCWR;
  localparam logic [15:0] V_IDLE    = A_NOST;
  localparam logic [15:0] V_LOD_MEM = A_NI | B_MMSEL | B_MREQ;
  localparam logic [15:0] V_STR_MEM = A_NI | B_MMSEL | B_MREQ | B_DMWE | B_RBSEL;

  logic [15:0] out_v;
  assign out_v = {bus.rf_we, bus.alu_op, bus.wb_sel, bus.br_sel, bus.rb_sel,
                  bus.ir_load, bus.pc_sel, bus.pc_write, bus.pc_rst, bus.mm_sel,
                  bus.mem_req, bus.dm_we, bus.halted, bus.fault, bus.illegal};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  // Inputs are already set; sample mid-cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [15:0] exp);
    #1 check(tag, out_v, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [3:0] mm,
                        input logic [3:0] st, input logic rdy);
    bus.opcode  = op;
    bus.mm      = mm;
    bus.stat    = st;
    bus.mem_rdy = rdy;
  endtask

  initial begin
    rst_f = 1'b1;
    set_in(4'd0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_f = 1'b0;
    step("reset_state", V_RESET);

    // ALU ADD register mode, memory always ready
    set_in(4'd8, 4'd0, 4'd0, 1'b1);
    step("add_fetch", V_F_RDY);
    step("add_decode", V_IDLE);
    step("add_exec", A_REG);
    step("add_mem", A_NOST);
    step("add_wb", V_IDLE | B_RFWE);

    // ALU immediate mode (mm == IMM_MODE)
    set_in(4'd8, 4'd8, 4'd0, 1'b1);
    step("addi_fetch", V_F_RDY);
    step("addi_decode", V_IDLE);
    step("addi_exec", A_IMM);
    step("addi_mem", A_NI);
    step("addi_wb", V_IDLE | B_RFWE);

    // BRA taken, short path back to FETCH
    set_in(4'd4, 4'b0010, 4'b0010, 1'b1);
    step("bra_fetch", V_F_RDY);
    step("bra_taken", V_IDLE | B_PCSEL | B_PCWR | B_BRSEL);
    set_in(4'd4, 4'b0010, 4'b0000, 1'b1);
    step("bra_nt_fetch", V_F_RDY);
    step("bra_not_taken", V_IDLE | B_BRSEL);
    set_in(4'd7, 4'b0000, 4'b1111, 1'b1);
    step("bnr_fetch", V_F_RDY);
    step("bnr_mm0_taken", V_IDLE | B_PCSEL | B_PCWR);

    // LOD with three wait cycles in MEM
    set_in(4'd1, 4'd0, 4'd0, 1'b1);
    step("lod_fetch", V_F_RDY);
    step("lod_decode", V_IDLE);
    step("lod_exec", A_NI);
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) step("lod_mem_wait", V_LOD_MEM);
    bus.mem_rdy = 1'b1;
    step("lod_mem_rdy", V_LOD_MEM);
    step("lod_wb", V_IDLE | B_RFWE | B_WBSEL);

    // STR with three wait cycles in MEM
    set_in(4'd2, 4'd0, 4'd0, 1'b1);
    step("str_fetch", V_F_RDY);
    step("str_decode", V_IDLE);
    step("str_exec", A_NI | B_RBSEL);
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) step("str_mem_wait", V_STR_MEM);
    bus.mem_rdy = 1'b1;
    step("str_mem_rdy", V_STR_MEM);
    step("str_wb", V_IDLE);

    // Illegal opcode 3: pulse then full NOOP walk
    set_in(4'd3, 4'd0, 4'd0, 1'b1);
    step("ill_fetch", V_F_RDY);
    step("ill_decode", V_IDLE | B_ILL);
    step("ill_exec", V_IDLE);
    step("ill_mem", V_IDLE);
    step("ill_wb", V_IDLE);

    // NOOP fetch: ready arrives on the cycle the count reaches the limit
    set_in(4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) step("edge_fetch_wait", V_F_WAIT);
    bus.mem_rdy = 1'b1;
    step("edge_fetch_rdy", V_F_RDY);
    step("edge_decode", V_IDLE);
    step("noop_exec", V_IDLE);
    step("noop_mem", V_IDLE);
    step("noop_wb", V_IDLE);

    // Fetch timeout: five waiting cycles, fault on the sixth and sticky
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 5; i++) step("to_fetch_wait", V_F_WAIT);
    step("to_fault", V_IDLE | B_FAULT);
    bus.mem_rdy = 1'b1;
    step("to_fault_sticky", V_IDLE | B_FAULT);
    rst_f = 1'b1;
    step("to_fault_rst_cycle", V_IDLE | B_FAULT);
    rst_f = 1'b0;
    step("to_reset", V_RESET);

    // HLT: halted from the cycle after DECODE, no further PC writes
    set_in(4'd15, 4'd0, 4'd0, 1'b1);
    step("hlt_fetch", V_F_RDY);
    step("hlt_decode", V_IDLE);
    for (int i = 0; i < 3; i++) step("hlt_sticky", V_IDLE | B_HALT);
    rst_f = 1'b1;
    step("hlt_rst_cycle", V_IDLE | B_HALT);
    rst_f = 1'b0;
    step("hlt_reset", V_RESET);

    // Reset while a STR waits in MEM; reset wins over a simultaneous ready
    set_in(4'd2, 4'd0, 4'd0, 1'b1);
    step("strrst_fetch", V_F_RDY);
    step("strrst_decode", V_IDLE);
    step("strrst_exec", A_NI | B_RBSEL);
    bus.mem_rdy = 1'b0;
    step("strrst_mem_wait", V_STR_MEM);
    rst_f = 1'b1;
    bus.mem_rdy = 1'b1;
    step("strrst_mem_rst", V_STR_MEM);
    rst_f = 1'b0;
    step("strrst_reset", V_RESET);
    step("strrst_refetch", V_F_RDY);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
